piece_lander: RTL and testbench
===============================

Name: piece_lander

Overview:
- Consumer end of the shape-spawn interface. It pulses `refresh` to the shape initializer, captures the `newShape` bitmap that comes back, and drops the piece down the board on each gravity tick.
- Applies left/right moves, locks the piece into the settled board on landing, and collapses full rows.
- Signals game over when a freshly spawned shape overlaps the settled board.
- Sits between the initializer and the display/board renderer.

Parameters:
- COLS, 12, columns per row; row r occupies bits [12r+11:12r], column c is bit c of that row.
- ROWS, 12, rows; row 0 is top, row 11 is bottom.
- BW, 145, bitmap width; bit 144 is unused and always held 0 in `piece` and `board`.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  level; begin game from IDLE, or restart from OVER.
- tick  in  1  one-cycle gravity pulse.
- move_left  in  1  one-cycle pulse; shift piece toward column 0.
- move_right  in  1  one-cycle pulse; shift piece toward column 11.
- newShape  in  145  shape bitmap from the initializer.
- refresh  out  1  one-cycle spawn request to the initializer.
- piece  out  145  active falling piece.
- board  out  145  settled blocks.
- lines_cleared  out  8  count of collapsed rows, saturating at 255.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (async, resetn=0): state=IDLE; refresh=0, piece=0, board=0, lines_cleared=0, game_over=0.
- States: IDLE, REQ, WAIT, LOAD, FALL, LOCK, CLEAR, OVER. All other outputs are registered.
- IDLE: start=1 -> REQ.
- REQ: refresh=1 for exactly this cycle -> WAIT.
- WAIT: one cycle while the initializer updates its shape register -> LOAD.
- LOAD: samples `newShape` (bit 144 masked).
  - If (newShape & board) != 0 -> OVER; piece stays 0.
  - Else piece<=newShape -> FALL.
- FALL, event priority is tick, then move_left, then move_right; only one action per cycle.
  - move_left and move_right both high with no tick: both ignored.
  - tick:
    - If piece has no bit in row 11 and ((piece<<12) & board)==0, then piece<=piece<<12.
    - Else -> LOCK.
  - move_left: applied only if piece has no bit in column 0 and (piece_shifted & board)==0. piece_shifted is each row shifted by -1 column. Otherwise no change.
  - move_right: applied only if piece has no bit in column 11 and no collision after shifting by +1 column. Otherwise no change.
- LOCK: board<=board|piece; piece<=0; row pointer=11 -> CLEAR.
- CLEAR: examines one row per cycle, from row 11 up to row 0.
  - Full row (all 12 bits set): rows 0..r-1 move down one row, row 0 becomes 0, lines_cleared increments (saturating), and the same row r is re-examined next cycle.
  - Non-full row: pointer decrements.
  - After row 0 has been examined and is non-full -> REQ.
- OVER: game_over=1; board is frozen. start=1 -> board<=0, lines_cleared<=0, game_over<=0 -> REQ.
- tick, move_left and move_right are ignored outside FALL.
- Latency:
  - start to refresh: 1 cycle.
  - refresh to piece valid: 2 cycles.
  - Landing tick to next refresh: 2 cycles plus the number of CLEAR cycles. CLEAR takes 12 cycles plus one extra per cleared row.
- Reset asserted in any state returns to IDLE immediately; partial row collapses are discarded.

Decomposition:
- Shared package `tetris_pkg`:
  - COLS, ROWS, BW.
  - State encoding.
  - Column-0 and column-11 edge masks (145-bit constants).
  - Full-row mask 12'hFFF.
- One natural sub-module: `row_collapse`. Combinational; takes board and row index, returns the board with that row removed and upper rows shifted down, plus a `full` flag.

Test Plan:
- Spawn handshake:
  - Stimulus: reset released, start=1, initializer shape 145'h060060.
  - Response: refresh high for exactly 1 cycle, one cycle after start. piece==145'h060060 two cycles after refresh. game_over=0.
- Drop to floor:
  - Stimulus: box piece on an empty board, 10 ticks.
  - Response: piece == (145'h060060<<120). The 11th tick locks it: board == (145'h060060<<120), piece=0. refresh pulses after 12 CLEAR cycles.
- Wall clamp:
  - Stimulus: I-shape 145'h020020020020, move_right 7 times.
  - Response: after 6 moves piece == 145'h800800800800; the 7th move leaves it unchanged. Symmetrically, 6 move_left pulses stop at 145'h001001001001.
- Double line clear:
  - Stimulus: six boxes placed, using move_left 5/3/1 and move_right 1/3/5, covering columns 0-11 of rows 10-11.
  - Response: board==0 and lines_cleared==2 after the final CLEAR.
- Game over:
  - Stimulus: repeated I-shapes dropped without moves, so column 5 stacks up.
  - Response: the LOAD that overlaps sets game_over=1, refresh stays 0, and board is unchanged. start then gives board=0, game_over=0 and a refresh pulse.
- Async reset mid-CLEAR:
  - Stimulus: resetn driven low during a double-line collapse.
  - Response: board, piece, lines_cleared, refresh and game_over are all 0 in the same cycle, without waiting for a clock edge. The FSM stays in IDLE until start.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared constants, masks and state encoding for the falling-piece datapath.
package tetris_pkg;

  localparam int unsigned COLS    = 12;
  localparam int unsigned ROWS    = 12;
  localparam int unsigned BW      = 145;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned LINES_W = 8;

  localparam logic [COLS-1:0] FULL_ROW = 12'hFFF;

  // Edge masks: one bit per row in the leftmost / rightmost column.
  localparam logic [BW-1:0] COL0_MASK  = {1'b0, {ROWS{12'h001}}};
  localparam logic [BW-1:0] COL11_MASK = {1'b0, {ROWS{12'h800}}};

  // Bottom row, and every bit except the unused top bit.
  localparam logic [BW-1:0] ROW11_MASK = {1'b0, FULL_ROW, {(BW-1-COLS){1'b0}}};
  localparam logic [BW-1:0] VALID_MASK = {1'b0, {(BW-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_FALL,
    S_LOCK,
    S_CLEAR,
    S_OVER
  } state_t;

endpackage

// File: rtl/row_collapse.sv
// Removes one row from the board, shifting every row above it down by one.
module row_collapse
  import tetris_pkg::*;
(
  input  logic [BW-1:0]    board,
  input  logic [ROW_W-1:0] row,
  output logic [BW-1:0]    collapsed,
  output logic             full
);

  logic [COLS-1:0] rows_in  [ROWS];
  logic [COLS-1:0] rows_out [ROWS];

  // Rows at or above the removed one take the row above; row 0 always empties.
  for (genvar i = 0; i < ROWS; i++) begin : g_rows
    assign rows_in[i] = board[i*COLS +: COLS];
    if (i == 0) begin : g_top
      assign rows_out[i] = '0;
    end else begin : g_rest
      assign rows_out[i] = (ROW_W'(i) > row) ? rows_in[i] : rows_in[i-1];
    end
    assign collapsed[i*COLS +: COLS] = rows_out[i];
  end

  assign collapsed[BW-1] = 1'b0;
  assign full            = (rows_in[row] == FULL_ROW);

endmodule

// File: rtl/piece_lander.sv
// Spawns, moves, drops and locks pieces; collapses full rows after each lock.
module piece_lander
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               tick,
  input  logic               move_left,
  input  logic               move_right,
  input  logic [BW-1:0]      newShape,
  output logic               refresh,
  output logic [BW-1:0]      piece,
  output logic [BW-1:0]      board,
  output logic [LINES_W-1:0] lines_cleared,
  output logic               game_over
);

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     ptr_q, ptr_d;
  logic [BW-1:0]        piece_d, board_d;
  logic [LINES_W-1:0]   lines_d;
  logic                 refresh_d, game_over_d;

  logic [BW-1:0]        shape_in;
  logic [BW-1:0]        piece_down, piece_left, piece_right;
  logic                 can_down, can_left, can_right;
  logic [BW-1:0]        collapsed;
  logic                 row_full;

  assign shape_in    = newShape & VALID_MASK;
  assign piece_down  = piece << COLS;
  assign piece_left  = piece >> 1;
  assign piece_right = piece << 1;

  // Moves are legal only when nothing crosses an edge or lands on settled blocks.
  assign can_down  = ~|(piece & ROW11_MASK) && ~|(piece_down & board);
  assign can_left  = ~|(piece & COL0_MASK)  && ~|(piece_left & board);
  assign can_right = ~|(piece & COL11_MASK) && ~|(piece_right & board);

  row_collapse u_collapse (
    .board     (board),
    .row       (ptr_q),
    .collapsed (collapsed),
    .full      (row_full)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    piece_d = piece;
    board_d = board;
    lines_d = lines_cleared;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        if (|(shape_in & board)) begin
          state_d = S_OVER;
        end else begin
          piece_d = shape_in;
          state_d = S_FALL;
        end
      end
      S_FALL: begin
        if (tick) begin
          if (can_down) piece_d = piece_down;
          else          state_d = S_LOCK;
        end else if (move_left && !move_right) begin
          if (can_left) piece_d = piece_left;
        end else if (move_right && !move_left) begin
          if (can_right) piece_d = piece_right;
        end
      end
      S_LOCK: begin
        board_d = board | piece;
        piece_d = '0;
        ptr_d   = ROW_W'(ROWS - 1);
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        // A full row is removed and the same pointer re-examined next cycle.
        if (row_full) begin
          board_d = collapsed;
          if (lines_cleared != {LINES_W{1'b1}}) lines_d = lines_cleared + LINES_W'(1);
        end else if (ptr_q == '0) begin
          state_d = S_REQ;
        end else begin
          ptr_d = ptr_q - ROW_W'(1);
        end
      end
      S_OVER: begin
        if (start) begin
          board_d = '0;
          lines_d = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    refresh_d   = (state_d == S_REQ);
    game_over_d = (state_d == S_OVER);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      piece         <= '0;
      board         <= '0;
      lines_cleared <= '0;
      refresh       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      piece         <= piece_d;
      board         <= board_d;
      lines_cleared <= lines_d;
      refresh       <= refresh_d;
      game_over     <= game_over_d;
    end
  end

endmodule

// File: tb/tb_piece_lander.sv
// Directed bench for piece_lander: spawn, drop, walls, line clears, game over, reset.
module tb_piece_lander;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         tick = 1'b0;
  logic         move_left = 1'b0;
  logic         move_right = 1'b0;
  logic [144:0] newShape = '0;
  logic         refresh;
  logic [144:0] piece;
  logic [144:0] board;
  logic [7:0]   lines_cleared;
  logic         game_over;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [144:0] BOX       = 145'h060060;
  localparam logic [144:0] I_SHAPE   = 145'h020020020020;
  localparam logic [144:0] I_RIGHT   = 145'h800800800800;
  localparam logic [144:0] I_LEFT    = 145'h001001001001;
  localparam logic [144:0] COL5_FULL = {1'b0, {12{12'h020}}};

  piece_lander dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .tick          (tick),
    .move_left     (move_left),
    .move_right    (move_right),
    .newShape      (newShape),
    .refresh       (refresh),
    .piece         (piece),
    .board         (board),
    .lines_cleared (lines_cleared),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick;
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic pulse_left;
    move_left = 1'b1; cyc(); move_left = 1'b0;
  endtask

  task automatic pulse_right;
    move_right = 1'b1; cyc(); move_right = 1'b0;
  endtask

  task automatic drop(input int n);
    repeat (n) pulse_tick();
  endtask

  task automatic do_reset;
    start = 1'b0; tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  // From IDLE: start, then ride REQ/WAIT/LOAD into FALL.
  task automatic begin_game;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  // Advance until refresh is seen; cycles taken returned in n.
  task automatic wait_refresh(output int n);
    n = 0;
    while (refresh !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (refresh !== 1'b1) begin
      n_bad++;
      $display("FAIL refresh_timeout: refresh=%b after %0d cycles, required 1", refresh, n);
    end
  endtask

  task automatic load_next;
    cyc(); cyc(); cyc();
  endtask

  // Six boxes tiling columns 0-11 of rows 10-11; returns with the last in LOCK.
  task automatic place_six;
    int lefts[6]  = '{5, 3, 1, 0, 0, 0};
    int rights[6] = '{0, 0, 0, 1, 3, 5};
    int n;
    for (int k = 0; k < 6; k++) begin
      repeat (lefts[k]) pulse_left();
      repeat (rights[k]) pulse_right();
      drop(11);
      if (k < 5) begin
        wait_refresh(n);
        load_next();
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #3;
    n_cmp++;
    if ({refresh, game_over, lines_cleared} !== 10'd0 || piece !== '0 || board !== '0) begin
      n_bad++;
      $display("FAIL reset_values: refresh=%b go=%b lines=%0d piece=%h board=%h, required all 0",
               refresh, game_over, lines_cleared, piece, board);
    end
    cyc();
    resetn = 1'b1;
    cyc(); cyc();
    n_cmp++;
    if (refresh !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_refresh: refresh=%b, required 0", refresh);
    end
  endtask

  task automatic test_spawn;
    newShape = BOX;
    start = 1'b1; cyc(); start = 1'b0;
    n_cmp++;
    if (refresh !== 1'b1) begin
      n_bad++; $display("FAIL spawn_refresh_rise: refresh=%b, required 1", refresh);
    end
    cyc();
    n_cmp++;
    if (refresh !== 1'b0) begin
      n_bad++; $display("FAIL spawn_refresh_width: refresh=%b, required 0", refresh);
    end
    cyc();
    n_cmp++;
    if (piece !== '0) begin
      n_bad++; $display("FAIL spawn_piece_early: piece=%h, required 0", piece);
    end
    cyc();
    n_cmp++;
    if (piece !== BOX || game_over !== 1'b0) begin
      n_bad++; $display("FAIL spawn_piece: piece=%h go=%b, required %h go=0", piece, game_over, BOX);
    end
  endtask

  task automatic test_drop;
    logic [144:0] floor_box;
    int n;
    floor_box = BOX << 120;
    drop(10);
    n_cmp++;
    if (piece !== floor_box) begin
      n_bad++; $display("FAIL drop_floor: piece=%h, required %h", piece, floor_box);
    end
    pulse_tick();
    cyc();
    n_cmp++;
    if (board !== floor_box || piece !== '0) begin
      n_bad++; $display("FAIL drop_lock: board=%h piece=%h, required board=%h piece=0", board, piece, floor_box);
    end
    wait_refresh(n);
    n_cmp++;
    if (n != 12) begin
      n_bad++; $display("FAIL drop_clear_cycles: got %0d, required 12", n);
    end
    n_cmp++;
    if (lines_cleared !== 8'd0) begin
      n_bad++; $display("FAIL drop_lines: got %0d, required 0", lines_cleared);
    end
  endtask

  task automatic test_wall_clamp;
    do_reset();
    newShape = I_SHAPE;
    begin_game();
    move_left = 1'b1; move_right = 1'b1; cyc(); move_left = 1'b0; move_right = 1'b0;
    n_cmp++;
    if (piece !== I_SHAPE) begin
      n_bad++; $display("FAIL both_moves_ignored: piece=%h, required %h", piece, I_SHAPE);
    end
    repeat (6) pulse_right();
    n_cmp++;
    if (piece !== I_RIGHT) begin
      n_bad++; $display("FAIL right_wall: piece=%h, required %h", piece, I_RIGHT);
    end
    pulse_right();
    n_cmp++;
    if (piece !== I_RIGHT) begin
      n_bad++; $display("FAIL right_clamp: piece=%h, required %h", piece, I_RIGHT);
    end
    repeat (11) pulse_left();
    n_cmp++;
    if (piece !== I_LEFT) begin
      n_bad++; $display("FAIL left_wall: piece=%h, required %h", piece, I_LEFT);
    end
    pulse_left();
    n_cmp++;
    if (piece !== I_LEFT) begin
      n_bad++; $display("FAIL left_clamp: piece=%h, required %h", piece, I_LEFT);
    end
    tick = 1'b1; move_right = 1'b1; cyc(); tick = 1'b0; move_right = 1'b0;
    n_cmp++;
    if (piece !== (I_LEFT << 12)) begin
      n_bad++; $display("FAIL tick_priority: piece=%h, required %h", piece, I_LEFT << 12);
    end
  endtask

  task automatic test_double_clear;
    int n;
    do_reset();
    newShape = BOX;
    begin_game();
    place_six();
    wait_refresh(n);
    n_cmp++;
    if (n != 15) begin
      n_bad++; $display("FAIL double_clear_cycles: got %0d, required 15", n);
    end
    n_cmp++;
    if (board !== '0 || lines_cleared !== 8'd2) begin
      n_bad++; $display("FAIL double_clear: board=%h lines=%0d, required board=0 lines=2", board, lines_cleared);
    end
  endtask

  task automatic test_game_over;
    int n;
    do_reset();
    newShape = I_SHAPE;
    begin_game();
    drop(9);
    wait_refresh(n); load_next();
    drop(5);
    wait_refresh(n); load_next();
    drop(1);
    wait_refresh(n); load_next();
    n_cmp++;
    if (game_over !== 1'b1 || piece !== '0 || board !== COL5_FULL) begin
      n_bad++; $display("FAIL game_over_entry: go=%b piece=%h board=%h, required go=1 piece=0 board=%h",
                        game_over, piece, board, COL5_FULL);
    end
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      n_cmp++;
      if (refresh !== 1'b0 || game_over !== 1'b1 || board !== COL5_FULL) begin
        n_bad++; $display("FAIL game_over_hold: refresh=%b go=%b board=%h, required 0/1/%h",
                          refresh, game_over, board, COL5_FULL);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    n_cmp++;
    if (board !== '0 || game_over !== 1'b0 || refresh !== 1'b1 || lines_cleared !== 8'd0) begin
      n_bad++; $display("FAIL restart: board=%h go=%b refresh=%b lines=%0d, required 0/0/1/0",
                        board, game_over, refresh, lines_cleared);
    end
  endtask

  task automatic test_reset_mid_clear;
    do_reset();
    newShape = BOX;
    begin_game();
    place_six();
    cyc(); cyc();
    n_cmp++;
    if (lines_cleared !== 8'd1) begin
      n_bad++; $display("FAIL mid_clear_progress: lines=%0d, required 1", lines_cleared);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({refresh, game_over, lines_cleared} !== 10'd0 || piece !== '0 || board !== '0) begin
      n_bad++; $display("FAIL async_reset: refresh=%b go=%b lines=%0d piece=%h board=%h, required all 0",
                        refresh, game_over, lines_cleared, piece, board);
    end
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++;
      if (refresh !== 1'b0 || board !== '0) begin
        n_bad++; $display("FAIL post_reset_idle: refresh=%b board=%h, required 0/0", refresh, board);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    n_cmp++;
    if (refresh !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_start: refresh=%b, required 1", refresh);
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_drop();
    test_wall_clamp();
    test_double_clear();
    test_game_over();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
